// File: rtl/spi_slave.sv
// SPI mode-0 target engine: MSB-first 8-bit frames with one-entry TX/RX holding registers.
// Optional sticky RX overrun flag when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic       rx_overrun,
  input  logic       rx_overrun_clr
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic       sclk_prev_reg;
  logic [7:0] tx_buf_reg;
  logic       tx_full_reg;
  logic [7:0] tx_shift_reg;
  logic [7:0] rx_shift_reg;
  logic [2:0] bcnt_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;

  logic sclk_s, cs_s, mosi_s;
  logic cs_fall, cs_rise;
  logic bit_rise, bit_fall, byte_load, byte_done;
  logic tx_accept, rx_take;
  logic [7:0] rx_byte;

  // cs_n synchronisers reset to 1 so reset release never looks like a select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
      sclk_prev_reg <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cs_fall    = 1'b0;
    cs_rise    = 1'b0;
    case (state_reg)
      IDLE: if (!cs_s) begin
        state_next = ACTIVE;
        cs_fall    = 1'b1;
      end
      ACTIVE: if (cs_s) begin
        state_next = IDLE;
        cs_rise    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bit_rise  = (state_reg == ACTIVE) && !cs_s && sclk_s && !sclk_prev_reg;
  assign bit_fall  = (state_reg == ACTIVE) && !cs_s && !sclk_s && sclk_prev_reg;
  assign byte_load = cs_fall || (bit_fall && (bcnt_reg == 3'd0));
  assign byte_done = bit_rise && (bcnt_reg == 3'd7);
  assign rx_byte   = {rx_shift_reg[6:0], mosi_s};
  assign tx_accept = tx_valid && !tx_full_reg;
  assign rx_take   = rx_valid_reg && rx_ready;

  // A byte accepted during a load is kept for the next load; the load sees the old buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf_reg  <= 8'h00;
      tx_full_reg <= 1'b0;
    end else if (tx_accept) begin
      tx_buf_reg  <= tx_data;
      tx_full_reg <= 1'b1;
    end else if (byte_load) begin
      tx_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_reg <= 8'h00;
      rx_shift_reg <= 8'h00;
      bcnt_reg     <= 3'd0;
    end else if (cs_rise) begin
      tx_shift_reg <= 8'h00;
      rx_shift_reg <= 8'h00;
      bcnt_reg     <= 3'd0;
    end else begin
      if (byte_load)
        tx_shift_reg <= tx_full_reg ? tx_buf_reg : IDLE_BYTE;
      else if (bit_fall)
        tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
      if (bit_rise) begin
        rx_shift_reg <= rx_byte;
        bcnt_reg     <= bcnt_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
    end else if (byte_done && (!rx_valid_reg || rx_ready)) begin
      rx_data_reg  <= rx_byte;
      rx_valid_reg <= 1'b1;
    end else if (rx_take) begin
      rx_valid_reg <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_overrun_reg <= 1'b0;
    else if (byte_done && rx_valid_reg && !rx_ready)
      rx_overrun_reg <= 1'b1;
    else if (rx_overrun_clr)
      rx_overrun_reg <= 1'b0;
  end

  assign rx_overrun = rx_overrun_reg;
`endif

  assign miso     = tx_shift_reg[7];
  assign tx_ready = !tx_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 (CPOL=0, CPHA=0) peripheral-side engine, MSB first, 8-bit frames.
- Lets the CPU subsystem act as the target of an external SPI master, the opposite end of the link from our `spi` master.
- `sclk`, `cs_n` and `mosi` are asynchronous to `clk`. They are synchronised and edge-detected inside the block.
- One-entry TX and RX holding registers with valid/ready handshakes decouple the bus from the core.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each of `sclk`, `cs_n`, `mosi`. Minimum 2.
- `IDLE_BYTE`, default 8'h00: byte shifted out when the TX buffer is empty at a byte load.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `sclk  in  1`: SPI clock from the master.
- `cs_n  in  1`: chip select, active low.
- `mosi  in  1`: master-out data.
- `miso  out  1`: slave-out data. Always driven (no tristate).
- `tx_data  in  8`: next byte to return to the master.
- `tx_valid  in  1`: `tx_data` offered.
- `tx_ready  out  1`: TX buffer empty. A byte is accepted on a `clk` edge with `tx_valid && tx_ready`.
- `rx_data  out  8`: last received byte.
- `rx_valid  out  1`: `rx_data` holds an unconsumed byte.
- `rx_ready  in  1`: consumer takes the byte on a `clk` edge with `rx_valid && rx_ready`.
- `rx_overrun  out  1`: only with `SPI_SLAVE_OVERRUN_EN`.
- `rx_overrun_clr  in  1`: only with `SPI_SLAVE_OVERRUN_EN`.

## Operation
- **States:**
  - IDLE: synchronised `cs_n` = 1.
  - ACTIVE: synchronised `cs_n` = 0.
  - Bit counter `bcnt` runs 0..7 in ACTIVE and is held at 0 in IDLE.
- **IDLE -> ACTIVE (synchronised `cs_n` falling):**
  - Load the TX shift register with the TX buffer if full (buffer empties, `tx_ready` goes to 1), else with `IDLE_BYTE`.
  - `miso` = bit 7 of the loaded value.
- **Synchronised `sclk` rising, in ACTIVE:**
  - Shift synchronised `mosi` into the RX shift register LSB.
  - `bcnt` increments and wraps 7 -> 0.
  - On the wrap, the assembled byte completes.
- **Synchronised `sclk` falling, in ACTIVE:**
  - If `bcnt` != 0: shift the TX register left and drive the new bit 7 on `miso`.
  - If `bcnt` == 0 (byte boundary): reload as on entry to ACTIVE. This makes back-to-back bytes within one `cs_n` assertion seamless.
- **Byte complete:**
  - If `rx_valid` = 0, or `rx_ready` = 1 in the same cycle: `rx_data` <= byte, `rx_valid` <= 1.
  - Otherwise the new byte is dropped and the held byte is kept.
- **ACTIVE -> IDLE (`cs_n` rising):**
  - Abort immediately and discard the partial RX byte.
  - A TX byte already loaded into the shift register is lost.
  - `bcnt` = 0 and `miso` = 0.
- **Reset / reset mid-transfer:** every output clears immediately: `miso` 0, `tx_ready` 1, `rx_valid` 0, `rx_data` 8'h00, `rx_overrun` 0. All shift registers and `bcnt` clear.
- **Simultaneous events:**
  - A TX accept in the same cycle as a byte load: the load uses the old buffer state (`IDLE_BYTE` if it was empty), and the new byte is kept for the next load.
  - An RX consume in the same cycle as a byte complete delivers the new byte without loss.
- `sclk` edges while `cs_n` is high are ignored.

## Timing
- **Synchronisation latency:** a pin change is seen as an edge `SYNC_STAGES` clk cycles later. `mosi` passes through identical stages, so it stays aligned with `sclk`.
- **`miso` update:** registered on the clk edge following detection of a falling `sclk` or `cs_n` edge, i.e. `SYNC_STAGES`+1 cycles after the pin edge.
- **`rx_valid`:** rises `SYNC_STAGES`+1 cycles after the pin `sclk` rising edge of bit 0.
- **Master constraints:**
  - `sclk` high time and low time each ≥ `SYNC_STAGES`+2 clk periods.
  - First `sclk` rise ≥ `SYNC_STAGES`+2 clk periods after `cs_n` falls.
  - With defaults this requires clk ≥ 8× the `sclk` frequency.
- **`tx_ready`:** returns to 1 on the clk edge that performs the byte load.

## Configuration
- **`SPI_SLAVE_OVERRUN_EN` defined:**
  - `rx_overrun` becomes a sticky 1 on any dropped RX byte.
  - It clears on a clk edge with `rx_overrun_clr` = 1; set takes priority when both occur in the same cycle.
- **Not defined:** both ports are absent; drop behaviour is unchanged.

## Test plan
- **Reset:** `rst_n` = 0 mid-byte (after 3 bits) -> `miso` 0, `tx_ready` 1, `rx_valid` 0 immediately; a following full transfer is byte-correct.
- **Single byte:** clk 10 ns, `sclk` period 100 ns. Preload `tx_data` 8'hDE, master sends 8'hC5 -> `miso` bits 1,1,0,1,1,1,1,0 stable at each `sclk` rise; `rx_data` = 8'hC5 with `rx_valid` 1; `tx_ready` 1 after `cs_n` fall.
- **Back-to-back, empty buffer:** buffer 8'hA5, then 8'h3C written after the first load; master sends 8'h01, 8'h02 in one `cs_n` frame -> `miso` returns 8'hA5 then 8'h3C; RX yields 8'h01 then 8'h02 via handshake.
- **Empty TX:** no byte queued, `IDLE_BYTE` 8'h00 -> `miso` 8'h00 for the whole byte.
- **Overrun:** `rx_ready` held 0, two bytes 8'h11, 8'h22 sent -> `rx_data` stays 8'h11; `rx_overrun` 1 (macro on) until `rx_overrun_clr` pulses.
- **Abort:** `cs_n` raised after 5 bits -> no `rx_valid`; next frame sending 8'h5A yields `rx_data` 8'h5A.
